// File: rtl/ew_event_logger.sv
// ew_event_logger: timestamps fsm_state transitions and system_fault rising edges into a
// first-word fall-through FIFO drained over valid/ready. EW_LOG_DWELL_EN adds a dwell counter.
module ew_event_logger #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 32,
  parameter int unsigned DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   log_en,
  input  logic [2:0]             fsm_state,
  input  logic [1:0]             comm_channel,
  input  logic                   system_fault,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [TS_W+25:0]       evt_data,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic [DROP_W-1:0]      drop_count,
  output logic                   overflow,
  input  logic                   stat_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = TS_W + 26;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [TS_W-1:0]   r_ts;
  logic [2:0]        r_last_state;
  logic              r_last_fault;
  logic [RW-1:0]     r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic [DROP_W-1:0] r_drop;
  logic              r_ovf;

  logic              w_state_chg;
  logic              w_fault_edge;
  logic              w_capture;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [15:0]       w_dwell;
  logic [RW-1:0]     w_rec;

  always_comb begin
    w_state_chg  = (fsm_state != r_last_state);
    w_fault_edge = system_fault & ~r_last_fault;
    w_capture    = (w_state_chg | w_fault_edge) & log_en;
    w_full       = (r_count == FULL_CNT);
    w_pop        = (r_count != '0) & evt_ready;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    w_push       = w_capture & (~w_full | w_pop);
    w_drop       = w_capture & w_full & ~w_pop;
    w_rec        = {r_ts, w_dwell, r_last_state, fsm_state, comm_channel,
                    system_fault, w_fault_edge};
  end

`ifdef EW_LOG_DWELL_EN
  logic [15:0] r_dwell;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dwell <= '0;
    end else if (w_state_chg) begin
      r_dwell <= '0;
    end else if (r_dwell != '1) begin
      r_dwell <= r_dwell + 16'd1;
    end
  end

  // r_dwell lags by the current clock; the field reports clocks including this one.
  always_comb begin
    w_dwell = (r_dwell == '1) ? '1 : r_dwell + 16'd1;
  end
`else
  always_comb begin
    w_dwell = '0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts         <= '0;
      r_last_state <= '0;
      r_last_fault <= 1'b0;
    end else begin
      r_ts         <= r_ts + TS_W'(1);
      r_last_state <= fsm_state;
      r_last_fault <= system_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_rec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop coinciding with stat_clr restarts the count at one rather than clearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop <= '0;
      r_ovf  <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (stat_clr)            r_drop <= DROP_W'(1);
      else if (r_drop != '1)   r_drop <= r_drop + DROP_W'(1);
    end else if (stat_clr) begin
      r_drop <= '0;
      r_ovf  <= 1'b0;
    end
  end

  always_comb begin
    evt_valid  = (r_count != '0);
    evt_data   = evt_valid ? r_mem[r_rptr] : '0;
    evt_count  = r_count;
    drop_count = r_drop;
    overflow   = r_ovf;
  end

endmodule

// File: tb/tb_ew_event_logger.sv
// Scoreboard bench for ew_event_logger: stimulus pushes expected records, a negedge monitor
// pops and compares on every accepted handshake. Dwell is checked according to EW_LOG_DWELL_EN.
module tb_ew_event_logger;

  localparam int DEPTH = 16;
  localparam int TS_W  = 32;
  localparam int RW    = TS_W + 26;
`ifdef EW_LOG_DWELL_EN
  localparam logic [RW-1:0] DMASK = ~(58'hFFFF << 10);
  localparam logic [15:0]   DWELL_EXP = 16'd37;
`else
  localparam logic [RW-1:0] DMASK = '1;
  localparam logic [15:0]   DWELL_EXP = 16'd0;
`endif

  logic          clk;
  logic          reset;
  logic          log_en;
  logic [2:0]    st;
  logic [1:0]    ch;
  logic          flt;
  logic          rdy;
  logic          clr;
  logic          evt_valid;
  logic [RW-1:0] evt_data;
  logic [4:0]    evt_count;
  logic [15:0]   drop_count;
  logic          overflow;

  ew_event_logger #(.DEPTH(16), .TS_W(32), .DROP_W(16)) dut (
    .clk(clk), .reset(reset), .log_en(log_en), .fsm_state(st),
    .comm_channel(ch), .system_fault(flt), .evt_valid(evt_valid),
    .evt_ready(rdy), .evt_data(evt_data), .evt_count(evt_count),
    .drop_count(drop_count), .overflow(overflow), .stat_clr(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] msk_q[$];
  logic [RW-1:0] mon_e;
  logic [RW-1:0] mon_m;

  logic [2:0]  m_last;
  logic        m_lastf;
  int          m_cnt;
  logic [15:0] m_drop;
  logic        m_ovf;

  logic [31:0] tb_cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cyc <= 32'd0;
    else       tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && evt_valid && rdy) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got %0h expected no record", evt_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_m = msk_q.pop_front();
        if ((evt_data & mon_m) !== (mon_e & mon_m)) begin
          bad++;
          $display("FAIL sb_record: got %0h expected %0h", evt_data & mon_m, mon_e & mon_m);
        end
      end
    end
  end

  // Called at posedge+1; drives one clock of inputs and predicts its effect.
  task automatic tick(input logic [2:0] s, input logic f, input logic en,
                      input logic r, input logic c, input logic dchk);
    logic fe, trig, pop, drop;
    logic [15:0] dwl;
    logic [RW-1:0] msk;
    st = s; flt = f; log_en = en; rdy = r; clr = c;
    fe   = f & ~m_lastf;
    trig = (s != m_last) | fe;
    pop  = r && (m_cnt != 0);
    drop = 1'b0;
    dwl  = dchk ? DWELL_EXP : 16'd0;
    msk  = dchk ? '1 : DMASK;
    if (trig && en) begin
      if (m_cnt < DEPTH || pop) begin
        exp_q.push_back({tb_cyc, dwl, m_last, s, ch, f, fe});
        msk_q.push_back(msk);
        m_cnt++;
      end else begin
        drop  = 1'b1;
        m_ovf = 1'b1;
        if (c)                    m_drop = 16'd1;
        else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
    if (c && !drop) begin
      m_drop = 16'd0;
      m_ovf  = 1'b0;
    end
    if (pop) m_cnt--;
    m_last  = s;
    m_lastf = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", 64'(evt_valid), 64'd0);
    chk("rst_count", 64'(evt_count), 64'd0);
    chk("rst_data", 64'(evt_data), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    exp_q.delete();
    msk_q.delete();
    m_cnt = 0; m_last = 3'd0; m_lastf = 1'b0; m_drop = 16'd0; m_ovf = 1'b0;
    st = 3'd0; flt = 1'b0; rdy = 1'b0; clr = 1'b0; log_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    st = 3'd0; ch = 2'd2; flt = 1'b0; rdy = 1'b0; clr = 1'b0; log_en = 1'b1;
    do_reset();

    // Transition 0->1 captured at timestamp 5
    repeat (5) tick(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_count", 64'(evt_count), 64'd1);
    chk("t1_valid", 64'(evt_valid), 64'd1);
    chk("t1_data", 64'(evt_data & DMASK),
        64'({32'd5, 16'd0, 3'd0, 3'd1, 2'd2, 1'b0, 1'b0} & DMASK));
    tick(3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_drained", 64'(evt_count), 64'd0);

    // Simultaneous transition and fault edge -> one record at ts 7
    tick(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_count", 64'(evt_count), 64'd1);
    chk("t2_data", 64'(evt_data & DMASK),
        64'({32'd7, 16'd0, 3'd1, 3'd4, 2'd2, 1'b1, 1'b1} & DMASK));
    tick(3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_fall_no_rec", 64'(evt_count), 64'd0);
    // Fault-edge-only record at ts 10
    tick(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_fedge_data", 64'(evt_data & DMASK),
        64'({32'd10, 16'd0, 3'd4, 3'd4, 2'd2, 1'b1, 1'b1} & DMASK));
    tick(3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_empty", 64'(evt_count), 64'd0);

    // 18 transitions into a stalled FIFO
    ch = 2'd1;
    for (int i = 0; i < 18; i++) tick(3'(5 + i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_count", 64'(evt_count), 64'd16);
    chk("t3_drop", 64'(drop_count), 64'd2);
    chk("t3_ovf", 64'(overflow), 64'd1);
    tick(3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_full_pushpop_count", 64'(evt_count), 64'd16);
    chk("t3_full_pushpop_drop", 64'(drop_count), 64'd2);
    repeat (16) tick(3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_drained", 64'(evt_count), 64'd0);
    chk("t3_drop_kept", 64'(drop_count), 64'd2);
    tick(3'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t3_clr_drop", 64'(drop_count), 64'd0);
    chk("t3_clr_ovf", 64'(overflow), 64'd0);

    // stat_clr colliding with a drop, then clearing without touching the FIFO
    for (int i = 0; i < 16; i++) tick(3'(i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t3b_clr_drop_win", 64'(drop_count), 64'd1);
    chk("t3b_clr_ovf_win", 64'(overflow), 64'd1);
    tick(3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t3b_clr_drop", 64'(drop_count), 64'd0);
    chk("t3b_clr_keeps_fifo", 64'(evt_count), 64'd16);
    tick(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3b_noen_no_drop", 64'(drop_count), 64'd0);
    chk("t3b_noen_ovf", 64'(overflow), 64'd0);
    repeat (16) tick(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3b_noen_drain", 64'(evt_count), 64'd0);

    // log_en=0 still tracks state
    ch = 2'd3;
    tick(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_no_rec", 64'(evt_count), 64'd0);
    tick(3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_count", 64'(evt_count), 64'd1);
    chk("t4_fields", 64'(evt_data[9:0]), 64'({3'd2, 3'd5, 2'd3, 1'b0, 1'b0}));
    tick(3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Dwell: state 2 held 37 clocks, then 3
    tick(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (36) tick(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t5_dwell", 64'(evt_data[25:10]), 64'(DWELL_EXP));
    chk("t5_states", 64'(evt_data[9:4]), 64'({3'd2, 3'd3}));
    tick(3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset mid-drain
    tick(3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_pre_count", 64'(evt_count), 64'd3);
    rdy = 1'b1;
    #1;
    do_reset();
    ch = 2'd0;
    tick(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_post_data", 64'(evt_data & DMASK),
        64'({32'd0, 16'd0, 3'd0, 3'd1, 2'd0, 1'b0, 1'b0} & DMASK));
    tick(3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_post_empty", 64'(evt_count), 64'd0);
    chk("sb_leftover", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ew_event_logger.md
Name: ew_event_logger

Overview:
Downstream consumer of ew_sim_top. Watches fsm_state, comm_channel and system_fault every clock. Turns each FSM transition or fault assertion into a timestamped event record. Records are buffered in a FIFO and drained by a host or file-dump stage over a valid/ready stream, which replaces ad-hoc bench-side polling for heatmap logging.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
TS_W, 32, free-running timestamp width in clocks
DROP_W, 16, dropped-event counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
log_en  in  1  1 = capture events; 0 = track state only, no records
fsm_state  in  3  state code from ew_sim_top (0 IDLE … 6 THREAT_KNOWN)
comm_channel  in  2  active channel from ew_sim_top
system_fault  in  1  fault flag from ew_sim_top
evt_valid  out  1  head record available
evt_ready  in  1  consumer accepts head record
evt_data  out  TS_W+26  record: [TS_W+25:26] timestamp, [25:10] dwell, [9:7] prev_state, [6:4] new_state, [3:2] channel, [1] fault, [0] fault_edge
evt_count  out  $clog2(DEPTH)+1  FIFO occupancy
drop_count  out  DROP_W  events lost to full FIFO, saturating
overflow  out  1  sticky, set on first drop
stat_clr  in  1  synchronous clear of drop_count and overflow

Behaviour:
- Reset (async assert, sync release): timestamp=0, last_state=0, last_fault=0, FIFO empty, evt_valid=0, evt_data=0, evt_count=0, drop_count=0, overflow=0.
- Timestamp: increments every clock and wraps 2^TS_W-1 → 0. A record carries the counter value at its capture edge.
- Event detect at each rising edge:
  - trig = (fsm_state != last_state) OR (system_fault & ~last_fault).
  - last_state and last_fault update every clock, regardless of log_en.
- Capture: when trig & log_en, the record is built from the current inputs.
  - prev_state = last_state.
  - fault_edge = 1 only when the fault rising edge caused or co-occurred with the trigger.
  - A transition and a fault edge in the same cycle produce exactly one record.
- Latency: record written on the capture edge; evt_valid high from the following cycle when the FIFO was empty.
- FIFO: first-word fall-through, so evt_data reflects the head whenever evt_valid=1.
  - Pop on evt_valid & evt_ready.
  - evt_data holds stable while evt_valid=1 and evt_ready=0.
  - evt_data is don't-care when empty; the bench must not check it.
- Full:
  - A push is accepted if not full, or if a pop occurs in the same cycle (occupancy unchanged).
  - Otherwise the record is dropped: drop_count += 1, saturating at all-ones, and overflow is set.
- Empty: evt_ready is ignored and there is no pop or underflow.
- Pointers wrap modulo DEPTH. evt_count ranges 0..DEPTH.
- stat_clr: clears drop_count and overflow next edge.
  - A drop in the same cycle wins: drop_count=1, overflow=1.
  - stat_clr does not touch FIFO contents.
- log_en=0: no pushes and no drops are counted. The FIFO still drains.
- Mid-operation reset: all content is discarded immediately and evt_valid falls asynchronously.
- State codes 7 are logged like any other code, with no filtering.

Optional Feature:
EW_LOG_DWELL_EN
- Defined:
  - A 16-bit dwell counter counts clocks since the last fsm_state change and saturates at 0xFFFF.
  - Each record's dwell field holds the cycles spent in prev_state.
  - The counter resets to 0 on every state change, and on reset.
  - A fault-edge-only record reports the current dwell without resetting it.
- Not defined: the dwell field is constant 0 and no counter is synthesised.

Test Plan:
- Reset, log_en=1, drive fsm_state 0→1 at timestamp 5 → one record after 1 clock: ts=5, prev=0, new=1, fault_edge=0; evt_count=1.
- Same-cycle fsm_state 1→4 with system_fault 0→1 → single record: prev=1, new=4, fault=1, fault_edge=1; evt_count increments by 1 only.
- DEPTH=16, evt_ready=0, 18 distinct transitions → evt_count=16, drop_count=2, overflow=1; drain returns the first 16 records in order. Then stat_clr → drop_count=0, overflow=0.
- FIFO full with evt_ready=1 and a new transition in the same cycle → pop and push both happen, evt_count stays 16, drop_count unchanged.
- EW_LOG_DWELL_EN defined: hold state 2 for 37 clocks, then move to 3 → dwell=37. Without the macro → dwell=0.
- log_en=0 during transitions 0→1→2, then log_en=1 and 2→5 → only one record, prev=2, new=5. Assert reset mid-drain with evt_count=3 → evt_valid=0 and evt_count=0 immediately.
